mlp_output_layer_seq_avmm: RTL and testbench
============================================

# mlp_output_layer_seq_avmm

Parametrised, register-programmed output layer of the MLP accelerator. Holds its own weight matrix and bias vector, programmed over Avalon-MM. On a start command it computes `OUTPUT_SIZE` logits from a latched hidden vector using one sequential MAC, then tracks the argmax. Sits between the hidden-layer block, which drives `h_in_flat`, and the host CPU, which reads logits and class and takes an interrupt.

## Interface
- `HIDDEN_SIZE`, 8, hidden inputs per logit (1..64)
- `OUTPUT_SIZE`, 10, number of logits/classes (2..16)
- `IN_W`, 16, signed width of each hidden input
- `WEIGHT_W`, 8, signed weight width
- `ACC_W`, 32, signed accumulator/logit/bias width (16..32)
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high reset
- `avmm_address` in 7: word address
- `avmm_writedata` in 32: write data
- `avmm_write` in 1: write strobe
- `avmm_read` in 1: read strobe
- `avmm_readdata` out 32: read data, valid the cycle after `avmm_read`
- `avmm_waitrequest` out 1: constant 0
- `h_in_flat` in `IN_W*HIDDEN_SIZE`: hidden vector; element i is at `[i*IN_W +: IN_W]`
- `class_idx` out `$clog2(OUTPUT_SIZE)`: predicted class
- `one_hot` out `OUTPUT_SIZE`: one-hot of `class_idx`
- `busy` out 1: computation in progress
- `done` out 1: one-cycle pulse on completion
- `irq` out 1: `CTRL.irq_en & STATUS.done`

## Operation
- Register map (word addresses):
  - 0x00 CTRL: bit0 start (write-1 pulse, reads 0); bit1 irq_en (R/W).
  - 0x01 STATUS: bit0 busy (RO); bit1 done (sticky, write 1 to clear); bit2 ovf (sticky, W1C); bit3 cmd_err (sticky, W1C).
  - 0x02 CLASS: `class_idx` (RO).
  - 0x04 WPTR: weight pointer, 0..`HIDDEN_SIZE*OUTPUT_SIZE-1`.
  - 0x05 WDATA: write stores `writedata[WEIGHT_W-1:0]` at the current WPTR, then WPTR increments and wraps to 0 after the last index. Read returns the weight at WPTR, sign-extended, with no increment.
  - 0x10+j BIAS[j]: R/W, `ACC_W` bits, sign-extended on read.
  - 0x20+j LOGIT[j]: RO, sign-extended.
  - Unmapped addresses read 0; writes to them are ignored.
- Weight index for output j, input i: `j*HIDDEN_SIZE + i`.
- FSM states:
  - IDLE: a start write latches `h_in_flat` and goes to LOAD with j=0.
  - LOAD: acc = BIAS[j], i=0.
  - MAC: acc += h[i]*W[j][i], one product per cycle, `HIDDEN_SIZE` cycles.
  - STORE: LOGIT[j] = acc; argmax update; j++. Goes back to LOAD, or to FIN after j=`OUTPUT_SIZE-1`.
  - FIN: registers `class_idx`/`one_hot`, pulses `done`, sets STATUS.done, returns to IDLE.
- Argmax uses a strict greater-than compare, so on a tie the lowest index wins. Index 0 seeds the running maximum.
- Arithmetic: the product is signed `IN_W+WEIGHT_W` bits, sign-extended to `ACC_W` before the add.
- Any of these while busy is ignored and sets cmd_err:
  - a start write;
  - a write to WPTR, WDATA or BIAS.
- CTRL.irq_en and the STATUS W1C bits stay writable while busy.
- LOGIT reads while busy return each entry's latest stored value, so earlier indices may already hold the new result.
- STATUS.done set and a W1C on the same cycle: the set wins.

## Timing
- Start write at cycle 0: `busy` is high from cycle 1 for `OUTPUT_SIZE*(HIDDEN_SIZE+2)+1` cycles. That is 101 cycles for the defaults. `done` pulses in the last busy cycle.
- The hidden vector is sampled once, on the start-write edge. Later changes to `h_in_flat` have no effect on the running computation.
- `avmm_readdata` is registered with 1-cycle latency. It is 0 in cycles with no read.
- Reset values:
  - `avmm_readdata` = 0; `busy` = 0; `done` = 0; `irq` = 0.
  - `class_idx` = 0; `one_hot` = 0 (all zeros until the first completion).
  - All weights, biases, logits, WPTR, CTRL and STATUS = 0.
- Reset asserted mid-computation forces IDLE on the next edge with all of the above values. No `done` pulse is produced.

## Configuration
- `MLP_OUT_SAT_EN` defined: each accumulate saturates at the signed `ACC_W` limits. Any clamp sets STATUS.ovf, and accumulation continues from the clamped value.
- Not defined: the accumulate wraps in two's complement and STATUS.ovf always reads 0.

## Test plan
- **Basic compute.** Setup: all weights 1, BIAS[j]=j, h[i]=i (sum 28 for the defaults). Stimulus: start. Required: LOGIT[j]=28+j, `class_idx`=9, `one_hot`=0x200, `done` pulses exactly 101 cycles after the start write.
- **Tie-break.** Setup: all weights 0, BIAS[3]=BIAS[7]=5, all other biases 0. Required: `class_idx`=3.
- **Protocol.** Steps and required responses:
  - Write WPTR=79, then WDATA twice (0x11, 0x22): W[79]=0x11, W[0]=0x22, WPTR=1.
  - Start write during busy: cmd_err=1 and a single `done` pulse only.
  - Set irq_en, run to completion: `irq` rises; W1C of STATUS.done drops it.
- **Overflow.** Setup: h all 0x7FFF, weights 127, BIAS[0]=0x7FFFFFFF. Required with `MLP_OUT_SAT_EN`: LOGIT[0]=0x7FFFFFFF and ovf=1. Required without it: the wrapped value and ovf=0.
- **Reset mid-run.** Stimulus: assert `reset` 40 cycles after start. Required: next cycle `busy`=0; LOGIT, BIAS and weights read 0; `one_hot`=0; no `done` pulse.

Source files
------------

// File: rtl/mlp_output_layer_seq_avmm_if.sv
// Avalon-MM register-port bundle for the MLP output layer (host side = master).
interface mlp_output_layer_seq_avmm_if;
  logic [6:0]  avmm_address;
  logic [31:0] avmm_writedata;
  logic        avmm_write;
  logic        avmm_read;
  logic [31:0] avmm_readdata;
  logic        avmm_waitrequest;

  modport master (
    output avmm_address, avmm_writedata, avmm_write, avmm_read,
    input  avmm_readdata, avmm_waitrequest
  );

  modport slave (
    input  avmm_address, avmm_writedata, avmm_write, avmm_read,
    output avmm_readdata, avmm_waitrequest
  );
endinterface

// File: rtl/mlp_output_layer_seq_avmm.sv
// MLP output layer: register-programmed weights/biases, one sequential MAC, argmax.
// Optional feature macro MLP_OUT_SAT_EN: saturating accumulate with STATUS.ovf.
module mlp_output_layer_seq_avmm #(
  parameter int unsigned HIDDEN_SIZE = 8,
  parameter int unsigned OUTPUT_SIZE = 10,
  parameter int unsigned IN_W        = 16,
  parameter int unsigned WEIGHT_W    = 8,
  parameter int unsigned ACC_W       = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  mlp_output_layer_seq_avmm_if.slave    avmm,
  input  logic [IN_W*HIDDEN_SIZE-1:0]   h_in_flat,
  output logic [$clog2(OUTPUT_SIZE)-1:0] class_idx,
  output logic [OUTPUT_SIZE-1:0]        one_hot,
  output logic                          busy,
  output logic                          done,
  output logic                          irq
);

  localparam int unsigned NW     = HIDDEN_SIZE * OUTPUT_SIZE;
  localparam int unsigned WPW    = $clog2(NW);
  localparam int unsigned JW     = $clog2(OUTPUT_SIZE);
  localparam int unsigned IW     = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
  localparam int unsigned PROD_W = IN_W + WEIGHT_W;

  localparam logic [6:0] A_CTRL   = 7'h00;
  localparam logic [6:0] A_STATUS = 7'h01;
  localparam logic [6:0] A_CLASS  = 7'h02;
  localparam logic [6:0] A_WPTR   = 7'h04;
  localparam logic [6:0] A_WDATA  = 7'h05;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_STORE, S_FIN} state_t;

  state_t state_q, state_d;
  logic [JW-1:0]             j_q, j_d;
  logic [IW-1:0]             i_q, i_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [ACC_W-1:0]   best_val_q, best_val_d;
  logic [JW-1:0]             best_idx_q, best_idx_d;

  logic signed [WEIGHT_W-1:0] wmem_q  [NW];
  logic signed [ACC_W-1:0]    bias_q  [OUTPUT_SIZE];
  logic signed [ACC_W-1:0]    logit_q [OUTPUT_SIZE];
  logic signed [IN_W-1:0]     h_q     [HIDDEN_SIZE];
  logic [WPW-1:0]             wptr_q;
  logic                       irq_en_q, st_done_q, st_ovf_q, st_err_q;
  logic                       irq_en_d, st_done_d, st_ovf_d, st_err_d;
  logic [31:0]                rdata_q, rdata_c;

  logic [6:0]  addr;
  logic [31:0] wdata;
  logic        wr, idle, is_bias, is_logit, start_wr, cfg_wr, status_wr;
  logic        take_start, logit_we;
  logic [WPW-1:0]            widx;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   mac_acc;
`ifdef MLP_OUT_SAT_EN
  localparam int unsigned SUM_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [SUM_W-1:0] sum;
  logic                    mac_ovf, ovf_set;
`endif

  // Bus decode; configuration writes are only honoured while idle.
  always_comb begin
    addr      = avmm.avmm_address;
    wdata     = avmm.avmm_writedata;
    wr        = avmm.avmm_write;
    idle      = (state_q == S_IDLE);
    is_bias   = (addr[6:4] == 3'b001) && (32'(addr[3:0]) < OUTPUT_SIZE);
    is_logit  = (addr[6:4] == 3'b010) && (32'(addr[3:0]) < OUTPUT_SIZE);
    start_wr  = wr && (addr == A_CTRL) && wdata[0];
    cfg_wr    = wr && ((addr == A_WPTR) || (addr == A_WDATA) || is_bias);
    status_wr = wr && (addr == A_STATUS);
  end

  // Single MAC: product sign-extended into the accumulator.
  always_comb begin
    widx = WPW'(j_q) * WPW'(HIDDEN_SIZE) + WPW'(i_q);
    prod = PROD_W'(h_q[i_q]) * PROD_W'(wmem_q[widx]);
`ifdef MLP_OUT_SAT_EN
    sum     = SUM_W'(acc_q) + SUM_W'(prod);
    mac_acc = sum[ACC_W-1:0];
    mac_ovf = (sum != SUM_W'(mac_acc));
    if (mac_ovf) mac_acc = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
`else
    mac_acc = acc_q + ACC_W'(prod);
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    j_d        = j_q;
    i_d        = i_q;
    acc_d      = acc_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    take_start = 1'b0;
    logit_we   = 1'b0;
`ifdef MLP_OUT_SAT_EN
    ovf_set    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          state_d    = S_LOAD;
          j_d        = '0;
          take_start = 1'b1;
        end
      end
      S_LOAD: begin
        acc_d   = bias_q[j_q];
        i_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = mac_acc;
`ifdef MLP_OUT_SAT_EN
        ovf_set = mac_ovf;
`endif
        i_d = i_q + IW'(1);
        if (i_q == IW'(HIDDEN_SIZE - 1)) state_d = S_STORE;
      end
      S_STORE: begin
        logit_we = 1'b1;
        // Strict compare keeps the lowest index on ties.
        if ((j_q == '0) || (acc_q > best_val_q)) begin
          best_val_d = acc_q;
          best_idx_d = j_q;
        end
        if (j_q == JW'(OUTPUT_SIZE - 1)) begin
          state_d = S_FIN;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = S_LOAD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control/status next values; a done set beats a same-cycle clear.
  always_comb begin
    irq_en_d  = (wr && (addr == A_CTRL)) ? wdata[1] : irq_en_q;
    st_done_d = (st_done_q & ~(status_wr & wdata[1])) | (state_q == S_FIN);
`ifdef MLP_OUT_SAT_EN
    st_ovf_d  = (st_ovf_q & ~(status_wr & wdata[2])) | ovf_set;
`else
    st_ovf_d  = 1'b0;
`endif
    st_err_d  = (st_err_q & ~(status_wr & wdata[3])) | (~idle & (start_wr | cfg_wr));
  end

  // Read mux.
  always_comb begin
    rdata_c = '0;
    if (addr == A_CTRL)        rdata_c = {30'd0, irq_en_q, 1'b0};
    else if (addr == A_STATUS) rdata_c = {28'd0, st_err_q, st_ovf_q, st_done_q, busy};
    else if (addr == A_CLASS)  rdata_c = 32'(class_idx);
    else if (addr == A_WPTR)   rdata_c = 32'(wptr_q);
    else if (addr == A_WDATA)  rdata_c = 32'(wmem_q[wptr_q]);
    else if (is_bias)          rdata_c = 32'(bias_q[addr[3:0]]);
    else if (is_logit)         rdata_c = 32'(logit_q[addr[3:0]]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      j_q        <= '0;
      i_q        <= '0;
      acc_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      wptr_q     <= '0;
      irq_en_q   <= 1'b0;
      st_done_q  <= 1'b0;
      st_ovf_q   <= 1'b0;
      st_err_q   <= 1'b0;
      rdata_q    <= '0;
      class_idx  <= '0;
      one_hot    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      irq        <= 1'b0;
      for (int k = 0; k < NW; k++)          wmem_q[k]  <= '0;
      for (int k = 0; k < OUTPUT_SIZE; k++) bias_q[k]  <= '0;
      for (int k = 0; k < OUTPUT_SIZE; k++) logit_q[k] <= '0;
      for (int k = 0; k < HIDDEN_SIZE; k++) h_q[k]     <= '0;
    end else begin
      state_q    <= state_d;
      j_q        <= j_d;
      i_q        <= i_d;
      acc_q      <= acc_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      irq_en_q   <= irq_en_d;
      st_done_q  <= st_done_d;
      st_ovf_q   <= st_ovf_d;
      st_err_q   <= st_err_d;
      irq        <= irq_en_d & st_done_d;
      busy       <= (state_d != S_IDLE);
      done       <= (state_d == S_FIN);
      rdata_q    <= avmm.avmm_read ? rdata_c : 32'd0;
      if (take_start) begin
        for (int k = 0; k < HIDDEN_SIZE; k++) h_q[k] <= h_in_flat[k*IN_W +: IN_W];
      end
      if (idle && wr && (addr == A_WPTR)) wptr_q <= wdata[WPW-1:0];
      if (idle && wr && (addr == A_WDATA)) begin
        wmem_q[wptr_q] <= wdata[WEIGHT_W-1:0];
        wptr_q         <= (wptr_q >= WPW'(NW - 1)) ? '0 : wptr_q + WPW'(1);
      end
      if (idle && wr && is_bias) bias_q[addr[3:0]] <= wdata[ACC_W-1:0];
      if (logit_we) logit_q[j_q] <= acc_q;
      if ((state_q == S_STORE) && (state_d == S_FIN)) begin
        class_idx <= best_idx_d;
        one_hot   <= OUTPUT_SIZE'(1) << best_idx_d;
      end
    end
  end

  assign avmm.avmm_readdata    = rdata_q;
  assign avmm.avmm_waitrequest = 1'b0;

endmodule

// File: tb/tb_mlp_output_layer_seq_avmm.sv
// Directed bench for mlp_output_layer_seq_avmm with hand-computed expectations.
module tb_mlp_output_layer_seq_avmm;
  localparam int unsigned HS   = 8;
  localparam int unsigned OS   = 10;
  localparam int unsigned IN_W = 16;
  localparam logic [6:0] A_CTRL   = 7'h00;
  localparam logic [6:0] A_STATUS = 7'h01;
  localparam logic [6:0] A_CLASS  = 7'h02;
  localparam logic [6:0] A_WPTR   = 7'h04;
  localparam logic [6:0] A_WDATA  = 7'h05;
  localparam logic [6:0] A_BIAS   = 7'h10;
  localparam logic [6:0] A_LOGIT  = 7'h20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [IN_W*HS-1:0] h_in_flat;
  logic [3:0]        class_idx;
  logic [OS-1:0]     one_hot;
  logic              busy, done, irq;

  mlp_output_layer_seq_avmm_if avmm ();

  mlp_output_layer_seq_avmm dut (
    .clk       (clk),
    .reset     (reset),
    .avmm      (avmm),
    .h_in_flat (h_in_flat),
    .class_idx (class_idx),
    .one_hot   (one_hot),
    .busy      (busy),
    .done      (done),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    avmm.avmm_address   = a;
    avmm.avmm_writedata = d;
    avmm.avmm_write     = 1'b1;
    @(posedge clk);
    #1 avmm.avmm_write  = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [31:0] d);
    avmm.avmm_address = a;
    avmm.avmm_read    = 1'b1;
    @(posedge clk);
    #1 avmm.avmm_read = 1'b0;
    d = avmm.avmm_readdata;
  endtask

  task automatic load_weights(input logic [31:0] v);
    wr(A_WPTR, 32'd0);
    for (int k = 0; k < int'(HS * OS); k++) wr(A_WDATA, v);
  endtask

  // Counts cycles from the cycle after the start write until done, bounded.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  logic [31:0] r;
  int cyc, c0;

  initial begin
    avmm.avmm_address   = '0;
    avmm.avmm_writedata = '0;
    avmm.avmm_write     = 1'b0;
    avmm.avmm_read      = 1'b0;
    h_in_flat           = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_class", 32'(class_idx), 32'd0);
    check("rst_onehot", 32'(one_hot), 32'd0);
    check("rst_rdata", avmm.avmm_readdata, 32'd0);
    check("waitreq", 32'(avmm.avmm_waitrequest), 32'd0);
    rd(A_STATUS, r); check("rst_status", r, 32'd0);
    rd(A_LOGIT + 7'd4, r); check("rst_logit4", r, 32'd0);

    // Basic compute: W=1, BIAS[j]=j, h[i]=i -> LOGIT[j]=28+j
    load_weights(32'd1);
    for (int j = 0; j < int'(OS); j++) wr(A_BIAS + 7'(j), 32'(j));
    for (int i = 0; i < int'(HS); i++) h_in_flat[i*IN_W +: IN_W] = 16'(i);
    wr(A_CTRL, 32'd1);
    for (int i = 0; i < int'(HS); i++) h_in_flat[i*IN_W +: IN_W] = 16'h0100;
    check("basic_busy1", 32'(busy), 32'd1);
    wait_done(cyc);
    check("basic_latency", 32'(cyc), 32'd101);
    check("basic_onehot", 32'(one_hot), 32'h200);
    check("basic_class", 32'(class_idx), 32'd9);
    step(1);
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_busy0", 32'(busy), 32'd0);
    rd(A_CLASS, r); check("basic_class_reg", r, 32'd9);
    for (int j = 0; j < int'(OS); j++) begin
      rd(A_LOGIT + 7'(j), r);
      check($sformatf("basic_logit%0d", j), r, 32'(28 + j));
    end
    rd(A_STATUS, r); check("basic_status", r, 32'h2);
    step(1);
    check("rdata_idle0", avmm.avmm_readdata, 32'd0);
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, r); check("status_w1c", r, 32'd0);

    // Tie-break: zero weights, BIAS[3]=BIAS[7]=5
    load_weights(32'd0);
    for (int j = 0; j < int'(OS); j++) wr(A_BIAS + 7'(j), (j == 3 || j == 7) ? 32'd5 : 32'd0);
    wr(A_CTRL, 32'd1);
    wait_done(cyc);
    check("tie_latency", 32'(cyc), 32'd101);
    step(1);
    rd(A_CLASS, r); check("tie_class", r, 32'd3);
    rd(A_LOGIT + 7'd7, r); check("tie_logit7", r, 32'd5);
    rd(A_LOGIT + 7'd0, r); check("tie_logit0", r, 32'd0);

    // Weight pointer wrap and sign-extended readback
    wr(A_WPTR, 32'd79);
    wr(A_WDATA, 32'h11);
    wr(A_WDATA, 32'h22);
    rd(A_WPTR, r); check("wptr_wrap", r, 32'd1);
    wr(A_WPTR, 32'd79);
    rd(A_WDATA, r); check("w79", r, 32'h11);
    wr(A_WPTR, 32'd0);
    rd(A_WDATA, r); check("w0", r, 32'h22);
    rd(A_WPTR, r); check("wptr_noinc", r, 32'd0);
    wr(A_WDATA, 32'h80);
    wr(A_WPTR, 32'd0);
    rd(A_WDATA, r); check("w0_sext", r, 32'hFFFF_FF80);
    wr(A_WDATA, 32'h0);

    // Start and config writes while busy are ignored and flag cmd_err
    c0 = done_cnt;
    wr(A_CTRL, 32'd1);
    step(5);
    wr(A_CTRL, 32'd1);
    wr(A_BIAS, 32'h1234);
    wait_done(cyc);
    check("busy_run_done", 32'(done), 32'd1);
    step(3);
    check("single_done", 32'(done_cnt - c0), 32'd1);
    rd(A_STATUS, r); check("cmd_err_status", r, 32'hA);
    rd(A_BIAS, r); check("bias_locked", r, 32'd0);
    wr(A_STATUS, 32'hE);
    rd(A_STATUS, r); check("status_clr", r, 32'd0);

    // Interrupt
    wr(A_CTRL, 32'd2);
    rd(A_CTRL, r); check("ctrl_irq_en", r, 32'd2);
    wr(A_CTRL, 32'd3);
    check("irq_low_busy", 32'(irq), 32'd0);
    wait_done(cyc);
    step(1);
    check("irq_rise", 32'(irq), 32'd1);
    wr(A_STATUS, 32'h2);
    check("irq_clear", 32'(irq), 32'd0);
    wr(A_CTRL, 32'd0);

    // Overflow: h=0x7FFF, W=127, BIAS[0]=0x7FFFFFFF
    load_weights(32'd127);
    wr(A_BIAS, 32'h7FFF_FFFF);
    for (int j = 1; j < int'(OS); j++) wr(A_BIAS + 7'(j), 32'd0);
    for (int i = 0; i < int'(HS); i++) h_in_flat[i*IN_W +: IN_W] = 16'h7FFF;
    wr(A_CTRL, 32'd1);
    wait_done(cyc);
    check("ovf_latency", 32'(cyc), 32'd101);
    step(1);
    rd(A_LOGIT + 7'd1, r); check("ovf_logit1", r, 32'h01FB_FC08);
`ifdef MLP_OUT_SAT_EN
    rd(A_LOGIT, r);  check("ovf_logit0_sat", r, 32'h7FFF_FFFF);
    rd(A_STATUS, r); check("ovf_status_sat", r, 32'h6);
    rd(A_CLASS, r);  check("ovf_class_sat", r, 32'd0);
`else
    rd(A_LOGIT, r);  check("ovf_logit0_wrap", r, 32'h81FB_FC07);
    rd(A_STATUS, r); check("ovf_status_wrap", r, 32'h2);
    rd(A_CLASS, r);  check("ovf_class_wrap", r, 32'd1);
`endif
    wr(A_STATUS, 32'h6);

    // Reset mid-run
    c0 = done_cnt;
    wr(A_CTRL, 32'd1);
    step(39);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_onehot", 32'(one_hot), 32'd0);
    check("mrst_class", 32'(class_idx), 32'd0);
    step(80);
    check("mrst_no_done", 32'(done_cnt - c0), 32'd0);
    rd(A_LOGIT + 7'd1, r); check("mrst_logit1", r, 32'd0);
    rd(A_BIAS, r);         check("mrst_bias0", r, 32'd0);
    rd(A_WDATA, r);        check("mrst_w0", r, 32'd0);
    rd(A_STATUS, r);       check("mrst_status", r, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
